fp_norm_shift_stage: RTL and testbench

FP_NORM_SHIFT_STAGE -- requirements
Module: fp_norm_shift_stage

---
 rtl/fp_norm_shift_stage.sv | 219 +++++++++++++++++++++
 tb/tb_fp_norm_shift_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_shift_stage.sv
// Normalisation shift stage sitting behind the Booth multiplier.
// Shifts the double-width product right, left or not at all, splits the
// result into the kept mantissa (upper half) and the discarded bits (lower
// half), and gathers a sticky bit from everything pushed off the LSB end.
// The operand side fields ride along unchanged.
// STAGES=1 does the whole shift in one register stage. STAGES=2 does the
// coarse part first and the fine part second. The result is identical for
// both depths.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           upstream handshake
//   sign_in, exp_in, over_flow_in operand fields from the multiplier
//   mant_in                       2*(MANT+1)-bit product
//   spe_case_a_in/_b_in           special-case codes
//   shift_type_in                 00 right, 01 left, 1x pass-through
//   shift_value_in                shift amount
//   out_valid / out_ready         downstream handshake
//   mant_out / discard_out        upper / lower half of the shifted product
//   sticky_out                    OR of the bits lost on a right shift
//   over_flow_out                 all-ones exponent or incoming overflow
//   over_flow1_out                incoming overflow only
//   sign_out, exp_out,
//   spe_case_a_out/_b_out         side fields, delayed
module fp_norm_shift_stage #(
    parameter int DW     = 16,
    parameter int EXP    = 4,
    parameter int MANT   = 10,
    parameter int SHIFT  = 5,
    parameter int STAGES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sign_in,
    input  logic [EXP-1:0]        exp_in,
    input  logic                  over_flow_in,
    input  logic [2*(MANT+1)-1:0] mant_in,
    input  logic [2:0]            spe_case_a_in,
    input  logic [2:0]            spe_case_b_in,
    input  logic [1:0]            shift_type_in,
    input  logic [SHIFT-1:0]      shift_value_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sign_out,
    output logic [EXP-1:0]        exp_out,
    output logic [2:0]            spe_case_a_out,
    output logic [2:0]            spe_case_b_out,
    output logic [MANT:0]         mant_out,
    output logic [MANT:0]         discard_out,
    output logic                  sticky_out,
    output logic                  over_flow_out,
    output logic                  over_flow1_out
);

    localparam int MANT_MUL = 2 * (MANT + 1);

    if (!(DW == 16 || DW == 32 || DW == 64) || !(STAGES == 1 || STAGES == 2) || SHIFT < 2)
    begin : g_bad_params
        $error("fp_norm_shift_stage: unsupported DW/STAGES/SHIFT combination");
    end

    typedef struct packed {
        logic           sign;
        logic [EXP-1:0] exp;
        logic [2:0]     spe_a;
        logic [2:0]     spe_b;
        logic           ovf;
        logic           ovf1;
    } side_t;

    // Shift amounts at or beyond the product width shift everything out,
    // which the language shift operators already give us as zero.
    function automatic logic [MANT_MUL-1:0] shift_mant(
        input logic [MANT_MUL-1:0] m,
        input logic [1:0]          t,
        input logic [SHIFT-1:0]    n
    );
        logic [MANT_MUL-1:0] r;
        if (t[1]) begin
            r = m;
        end else if (t[0]) begin
            r = m << n;
        end else begin
            r = m >> n;
        end
        return r;
    endfunction

    // Bits below position n are the ones a right shift by n drops. When n
    // covers the whole word, the mask becomes all ones.
    function automatic logic lost_bits(
        input logic [MANT_MUL-1:0] m,
        input logic [1:0]          t,
        input logic [SHIFT-1:0]    n
    );
        logic [MANT_MUL-1:0] keep_mask;
        keep_mask = {MANT_MUL{1'b1}} << n;
        return (t == 2'b00) && (|(m & ~keep_mask));
    endfunction

    side_t               side_in;
    logic                out_valid_q;
    side_t               out_side_q;
    logic [MANT_MUL-1:0] out_shift_q;
    logic                out_sticky_q;
    logic                load_out;

    assign side_in = {sign_in, exp_in, spe_case_a_in, spe_case_b_in,
                      (&exp_in) | over_flow_in, over_flow_in};

    // The output register takes new data when it is empty or its contents
    // leave this cycle.
    assign load_out = !out_valid_q || out_ready;

    if (STAGES == 1) begin : g_one
        logic [MANT_MUL-1:0] shift_d;
        logic                sticky_d;

        assign in_ready = load_out;
        assign shift_d  = shift_mant(mant_in, shift_type_in, shift_value_in);
        assign sticky_d = lost_bits(mant_in, shift_type_in, shift_value_in);

        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid_q  <= 1'b0;
                out_side_q   <= '0;
                out_shift_q  <= '0;
                out_sticky_q <= 1'b0;
            end else if (load_out) begin
                out_valid_q <= in_valid;
                if (in_valid) begin
                    out_side_q   <= side_in;
                    out_shift_q  <= shift_d;
                    out_sticky_q <= sticky_d;
                end
            end
        end
    end else begin : g_two
        localparam int FINE_W = (SHIFT + 1) / 2;
        localparam int CRS_W  = SHIFT - FINE_W;

        logic                s1_valid_q;
        side_t               s1_side_q;
        logic [MANT_MUL-1:0] s1_mant_q;
        logic                s1_sticky_q;
        logic [1:0]          s1_type_q;
        logic [FINE_W-1:0]   s1_fine_q;
        logic                load_s1;
        logic [SHIFT-1:0]    coarse_amt;
        logic [SHIFT-1:0]    fine_amt;
        logic [MANT_MUL-1:0] s1_mant_d;
        logic                s1_sticky_d;
        logic [MANT_MUL-1:0] shift_d;
        logic                sticky_d;

        assign load_s1  = !s1_valid_q || load_out;
        assign in_ready = load_s1;

        // Coarse amount keeps only the high bits, fine amount the low bits;
        // their sum is the full amount, so the lost bits of both steps
        // together are exactly the low bits a single shift would drop.
        assign coarse_amt  = {shift_value_in[SHIFT-1:FINE_W], {FINE_W{1'b0}}};
        assign fine_amt    = {{CRS_W{1'b0}}, s1_fine_q};
        assign s1_mant_d   = shift_mant(mant_in, shift_type_in, coarse_amt);
        assign s1_sticky_d = lost_bits(mant_in, shift_type_in, coarse_amt);
        assign shift_d     = shift_mant(s1_mant_q, s1_type_q, fine_amt);
        assign sticky_d    = s1_sticky_q | lost_bits(s1_mant_q, s1_type_q, fine_amt);

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid_q  <= 1'b0;
                s1_side_q   <= '0;
                s1_mant_q   <= '0;
                s1_sticky_q <= 1'b0;
                s1_type_q   <= '0;
                s1_fine_q   <= '0;
            end else if (load_s1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_side_q   <= side_in;
                    s1_mant_q   <= s1_mant_d;
                    s1_sticky_q <= s1_sticky_d;
                    s1_type_q   <= shift_type_in;
                    s1_fine_q   <= shift_value_in[FINE_W-1:0];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid_q  <= 1'b0;
                out_side_q   <= '0;
                out_shift_q  <= '0;
                out_sticky_q <= 1'b0;
            end else if (load_out) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_side_q   <= s1_side_q;
                    out_shift_q  <= shift_d;
                    out_sticky_q <= sticky_d;
                end
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign sign_out       = out_side_q.sign;
    assign exp_out        = out_side_q.exp;
    assign spe_case_a_out = out_side_q.spe_a;
    assign spe_case_b_out = out_side_q.spe_b;
    assign over_flow_out  = out_side_q.ovf;
    assign over_flow1_out = out_side_q.ovf1;
    assign mant_out       = out_shift_q[MANT_MUL-1:MANT+1];
    assign discard_out    = out_shift_q[MANT:0];
    assign sticky_out     = out_sticky_q;

endmodule

// File: tb/tb_fp_norm_shift_stage.sv
module tb_fp_norm_shift_stage;

    typedef struct {
        logic [35:0] pl;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, sign_in, over_flow_in;
    logic [3:0]  exp_in;
    logic [21:0] mant_in;
    logic [2:0]  sa_in, sb_in;
    logic [1:0]  type_in;
    logic [4:0]  val_in;

    logic [1:0]  in_ready_w, out_valid_w, sign_w, sticky_w, ovf_w, ovf1_w;
    logic [3:0]  exp_w  [2];
    logic [2:0]  sa_w   [2];
    logic [2:0]  sb_w   [2];
    logic [10:0] mant_w [2];
    logic [10:0] disc_w [2];

    int   n_compared = 0;
    int   n_mismatch = 0;
    logic started = 1'b0;
    logic check_empty = 1'b0;

    logic [4:0]  bvals [5] = '{5'd0, 5'd21, 5'd22, 5'd23, 5'd31};
    logic [10:0] got [3];
    int          got_n;
    logic        c_taken;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_compared++;
        if (act !== expv) begin
            n_mismatch++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic string nm(input string s, input int g);
        return $sformatf("%s_s%0d", s, g + 1);
    endfunction

    function automatic logic [35:0] payload(input int i);
        return {sign_w[i], exp_w[i], sa_w[i], sb_w[i], mant_w[i], disc_w[i],
                sticky_w[i], ovf_w[i], ovf1_w[i]};
    endfunction

    // Reference: plain integer arithmetic on the 22-bit product.
    function automatic logic [35:0] model(input logic s, input logic [3:0] e, input logic of,
                                          input logic [21:0] m, input logic [2:0] a,
                                          input logic [2:0] b, input logic [1:0] t,
                                          input logic [4:0] v);
        longint unsigned mm, sh, p;
        logic            st;
        logic [10:0]     hi, lo;
        mm = 64'(m);
        p  = 64'd1 << v;
        st = 1'b0;
        if (t[1]) begin
            sh = mm;
        end else if (v >= 5'd22) begin
            sh = 0;
            st = (t == 2'b00) && (mm != 0);
        end else if (t == 2'b00) begin
            sh = mm / p;
            st = (mm % p) != 0;
        end else begin
            sh = (mm * p) % (64'd1 << 22);
        end
        hi = 11'(sh / 2048);
        lo = 11'(sh % 2048);
        return {s, e, a, b, hi, lo, st, (e == 4'hF) | of, of};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fp_norm_shift_stage #(
            .DW(16), .EXP(4), .MANT(10), .SHIFT(5), .STAGES(g + 1)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .in_valid       (in_valid),
            .in_ready       (in_ready_w[g]),
            .sign_in        (sign_in),
            .exp_in         (exp_in),
            .over_flow_in   (over_flow_in),
            .mant_in        (mant_in),
            .spe_case_a_in  (sa_in),
            .spe_case_b_in  (sb_in),
            .shift_type_in  (type_in),
            .shift_value_in (val_in),
            .out_valid      (out_valid_w[g]),
            .out_ready      (out_ready),
            .sign_out       (sign_w[g]),
            .exp_out        (exp_w[g]),
            .spe_case_a_out (sa_w[g]),
            .spe_case_b_out (sb_w[g]),
            .mant_out       (mant_w[g]),
            .discard_out    (disc_w[g]),
            .sticky_out     (sticky_w[g]),
            .over_flow_out  (ovf_w[g]),
            .over_flow1_out (ovf1_w[g])
        );

        exp_t q[$];
        int   ecnt = 0;
        logic rst_edge = 1'b0;

        always @(posedge clk) begin
            exp_t e;
            ecnt++;
            rst_edge = rst;
            if (rst) begin
                q.delete();
            end else begin
                if (out_valid_w[g] && out_ready) begin
                    check(nm("pop_has_data", g), 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) void'(q.pop_front());
                end
                if (in_valid && in_ready_w[g]) begin
                    e.pl  = model(sign_in, exp_in, over_flow_in, mant_in, sa_in, sb_in, type_in, val_in);
                    e.acc = ecnt;
                    q.push_back(e);
                end
            end
        end

        always @(negedge clk) begin
            logic exp_v;
            if (started) begin
                exp_v = (q.size() > 0) ? ((ecnt - q[0].acc) >= g) : 1'b0;
                check(nm("out_valid", g), out_valid_w[g], exp_v);
                check(nm("in_ready", g), in_ready_w[g], (q.size() < g + 1) || out_ready);
                if (exp_v && out_valid_w[g]) check(nm("payload", g), payload(g), q[0].pl);
                if (rst_edge) check(nm("reset_zero", g), payload(g), 64'd0);
                if (check_empty) check(nm("drained", g), q.size(), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string s, input int i, input logic [35:0] epl);
        check({s, "_valid"}, out_valid_w[i], 64'd1);
        check({s, "_data"}, payload(i), epl);
    endtask

    task automatic directed(input string s, input logic [21:0] m, input logic [1:0] t,
                            input logic [4:0] v, input logic [3:0] e, input logic of,
                            input logic [10:0] em, input logic [10:0] ed, input logic est,
                            input logic eo, input logic eo1);
        logic [35:0] epl;
        epl = {1'b1, e, 3'd5, 3'd2, em, ed, est, eo, eo1};
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        sign_in = 1'b1; exp_in = e; over_flow_in = of; mant_in = m;
        sa_in = 3'd5; sb_in = 3'd2; type_in = t; val_in = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_lit({s, "_s1"}, 0, epl);
        tick();
        @(negedge clk);
        check_lit({s, "_s2"}, 1, epl);
    endtask

    task automatic drive_pass(input logic [21:0] m);
        sign_in = 1'b0; exp_in = 4'h3; over_flow_in = 1'b0; mant_in = m;
        sa_in = 3'd1; sb_in = 3'd1; type_in = 2'b10; val_in = 5'd0;
        in_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sign_in = 1'b0;
        over_flow_in = 1'b0; exp_in = '0; mant_in = '0; sa_in = '0; sb_in = '0;
        type_in = '0; val_in = '0;
        tick();
        tick();
        started = 1'b1;
        tick();
        rst = 1'b0;

        directed("right1",      22'h200000, 2'b00, 5'd1,  4'h3, 1'b0, 11'h200, 11'h000, 1'b0, 1'b0, 1'b0);
        directed("right_stky",  22'h200007, 2'b00, 5'd3,  4'h3, 1'b0, 11'h080, 11'h000, 1'b1, 1'b0, 1'b0);
        directed("left10",      22'h000800, 2'b01, 5'd10, 4'h3, 1'b0, 11'h400, 11'h000, 1'b0, 1'b0, 1'b0);
        directed("left13",      22'h000001, 2'b01, 5'd13, 4'h3, 1'b0, 11'h004, 11'h000, 1'b0, 1'b0, 1'b0);
        directed("pass",        22'h2AAAAA, 2'b10, 5'd7,  4'h3, 1'b0, 11'h555, 11'h2AA, 1'b0, 1'b0, 1'b0);
        directed("right8",      22'h3FFFFF, 2'b00, 5'd8,  4'h3, 1'b0, 11'h007, 11'h7FF, 1'b1, 1'b0, 1'b0);
        directed("right21",     22'h3FFFFF, 2'b00, 5'd21, 4'h3, 1'b0, 11'h000, 11'h001, 1'b1, 1'b0, 1'b0);
        directed("sat_right",   22'h3FFFFF, 2'b00, 5'd31, 4'h3, 1'b0, 11'h000, 11'h000, 1'b1, 1'b0, 1'b0);
        directed("sat_ovf",     22'h3FFFFF, 2'b00, 5'd31, 4'hF, 1'b0, 11'h000, 11'h000, 1'b1, 1'b1, 1'b0);
        directed("sat_left",    22'h3FFFFF, 2'b01, 5'd22, 4'h3, 1'b1, 11'h000, 11'h000, 1'b0, 1'b1, 1'b1);

        // Backpressure on the two-stage instance.
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        drive_pass(22'h100800);
        @(negedge clk);
        check("bp_ready_a", in_ready_w[1], 64'd1);
        tick();
        drive_pass(22'h200000);
        @(negedge clk);
        check("bp_ready_b", in_ready_w[1], 64'd1);
        tick();
        drive_pass(22'h001800);
        @(negedge clk);
        check("bp_ready_c", in_ready_w[1], 64'd0);
        check("bp_head", mant_w[1], 64'h201);
        tick();
        @(negedge clk);
        check("bp_ready_c2", in_ready_w[1], 64'd0);
        check("bp_hold", mant_w[1], 64'h201);
        tick();
        out_ready = 1'b1;
        got_n = 0;
        c_taken = 1'b0;
        for (int i = 0; i < 3; i++) got[i] = '0;
        for (int k = 0; k < 10 && got_n < 3; k++) begin
            @(negedge clk);
            if (out_valid_w[1] && got_n < 3) begin
                got[got_n] = mant_w[1];
                got_n++;
            end
            if (in_valid && in_ready_w[1]) c_taken = 1'b1;
            tick();
            if (c_taken) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_count", got_n, 64'd3);
        check("bp_order0", got[0], 64'h201);
        check("bp_order1", got[1], 64'h400);
        check("bp_order2", got[2], 64'h003);

        // Reset with both stages of the two-stage instance occupied.
        repeat (3) tick();
        out_ready = 1'b0;
        drive_pass(22'h155555);
        tick();
        drive_pass(22'h0AAAAA);
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_pre_full", out_valid_w[1], 64'd1);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid_w[1], 64'd0);
        check("rst_data", payload(1), 64'd0);
        check("rst_ready", in_ready_w[1], 64'd1);
        check("rst_ready_s1", in_ready_w[0], 64'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("rst_no_stale", out_valid_w[1], 64'd0);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst          = ($urandom_range(0, 299) == 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            sign_in      = 1'($urandom_range(0, 1));
            exp_in       = 4'($urandom_range(0, 15));
            over_flow_in = ($urandom_range(0, 7) == 0);
            sa_in        = 3'($urandom_range(0, 7));
            sb_in        = 3'($urandom_range(0, 7));
            type_in      = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) mant_in = 22'd1 << $urandom_range(0, 21);
            else                           mant_in = 22'($urandom());
            if ($urandom_range(0, 3) == 0) val_in = bvals[$urandom_range(0, 4)];
            else                           val_in = 5'($urandom_range(0, 31));
        end

        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) tick();
        check_empty = 1'b1;
        tick();
        check_empty = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
